// File: rtl/cpu_pkg.sv
// Shared definitions for the 10-bit CPU: word width, sequencing codes and
// fetch FSM states.
package cpu_pkg;

  localparam int unsigned WORD_W = 10;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FOP_NEXT = 2'd0,
    FOP_JUMP = 2'd1,
    FOP_JR   = 2'd2,
    FOP_HALT = 2'd3
  } fetch_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel plus the decoder instruction/sequencing
// handshake; master is the fetch unit, slave is the memory/decoder side.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;

  word_t      instr;
  logic       instr_valid;
  logic [1:0] fetch_op;
  logic       jump_control;
  word_t      jmp_addr;
  logic       branch_cond;
  word_t      jr_addr;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, fetch_op, jump_control, jmp_addr,
           branch_cond, jr_addr
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, fetch_op, jump_control, jmp_addr,
           branch_cond, jr_addr
  );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection from the decoder's sequencing response.
// All arithmetic is 10-bit and wraps silently.
module next_pc_calc
  import cpu_pkg::*;
(
  input  word_t     pc,
  input  fetch_op_e fetch_op,
  input  logic      jump_control,
  input  logic      branch_cond,
  input  word_t     jmp_addr,
  input  word_t     jr_addr,
  output word_t     pc_next,
  output word_t     pc_plus1
);

  word_t pc_rel;

  always_comb begin
    pc_plus1 = pc + word_t'(1);
    // jmp_addr is already sign-extended, so a plain modular add gives pc + offset
    pc_rel   = pc + jmp_addr;
    pc_next  = pc_plus1;
    case (fetch_op)
      FOP_NEXT: pc_next = pc_plus1;
      FOP_JUMP: pc_next = (jump_control || branch_cond) ? pc_rel : pc_plus1;
      FOP_JR:   pc_next = jr_addr;
      FOP_HALT: pc_next = pc;
      default:  pc_next = pc_plus1;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing: owns the PC, reads instruction memory over
// req/ack, issues each word to the decoder for one cycle, then steps the PC.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter word_t       RESET_PC = '0,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus,
  output word_t         pc,
  output word_t         pc_plus1,
  output logic          halted,
  output logic          fault,
  output logic [15:0]   icount
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e      state_q,  state_d;
  word_t       pc_q,     pc_d;
  word_t       instr_q,  instr_d;
  logic [15:0] icount_q, icount_d;
  logic [7:0]  wait_q,   wait_d;
  logic        req_q,    req_d;
  logic        valid_q,  valid_d;
  logic        halted_q, halted_d;
  logic        fault_q,  fault_d;

  fetch_op_e   fop;
  word_t       pc_next;

  assign fop = fetch_op_e'(bus.fetch_op);

  next_pc_calc u_next_pc (
    .pc           (pc_q),
    .fetch_op     (fop),
    .jump_control (bus.jump_control),
    .branch_cond  (bus.branch_cond),
    .jmp_addr     (bus.jmp_addr),
    .jr_addr      (bus.jr_addr),
    .pc_next      (pc_next),
    .pc_plus1     (pc_plus1)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    icount_d = icount_q;
    wait_d   = wait_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          wait_d  = '0;
          state_d = ISSUE;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) begin
            fault_d = 1'b1;
            state_d = HALT;
          end
        end
      end
      ISSUE: begin
        icount_d = icount_q + 16'd1;
        pc_d     = pc_next;
        state_d  = (fop == FOP_HALT) ? HALT : FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
    // Outputs are registered by decoding the state being entered
    req_d    = (state_d == FETCH);
    valid_d  = (state_d == ISSUE);
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      icount_q <= '0;
      wait_q   <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      icount_q <= icount_d;
      wait_q   <= wait_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign pc              = pc_q;
  assign halted          = halted_q;
  assign fault           = fault_q;
  assign icount          = icount_q;

  a_fault_halted: assert property (@(posedge clk) disable iff (!rst_n)
    fault_q |-> halted_q);
  a_req_fetch: assert property (@(posedge clk) disable iff (!rst_n)
    req_q == (state_q == FETCH));
  a_valid_issue: assert property (@(posedge clk) disable iff (!rst_n)
    valid_q == (state_q == ISSUE));
  a_halt_absorb: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == HALT) |=> (state_q == HALT) && (pc_q == $past(pc_q)));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory/decoder responder pushes expected
// issues from a reference model; a monitor pops and compares on instr_valid.
module tb_fetch_unit;

  localparam logic [9:0] RST_PC = 10'd0;
  localparam int         MAXW   = 8;

  typedef struct {
    int op;
    bit jc;
    bit bc;
    int jmp;
    int jr;
  } dec_t;

  typedef struct {
    int pc;
    int instr;
    int icnt;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pc, pc_plus1;
  logic        halted, fault;
  logic [15:0] icount;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .pc       (pc),
    .pc_plus1 (pc_plus1),
    .halted   (halted),
    .fault    (fault),
    .icount   (icount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] mem [1024];
  dec_t dec_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_pc, issued, lat, lat_fix, halt_cyc;
  bit   rand_en, rand_lat, no_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic dec_t mk(input int op, input bit jc, input bit bc, input int jmp, input int jr);
    dec_t d;
    d.op = op; d.jc = jc; d.bc = bc; d.jmp = jmp; d.jr = jr;
    return d;
  endfunction

  function automatic dec_t rand_dec();
    return mk(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
  endfunction

  // Memory and decoder responder; also the reference model of the sequencing rules.
  initial begin : driver
    int   wcnt;
    dec_t d;
    exp_t e;
    wcnt = 0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    bus.fetch_op = '0; bus.jump_control = 1'b0; bus.branch_cond = 1'b0;
    bus.jmp_addr = '0; bus.jr_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.imem_ack = 1'b0;
        wcnt = 0;
      end else begin
        if (bus.imem_req) begin
          if (!no_ack && wcnt >= lat) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem[bus.imem_addr];
            wcnt = 0;
          end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 10'($urandom);
            wcnt++;
          end
        end else begin
          bus.imem_ack = 1'b0;
          wcnt = 0;
        end
        if (bus.instr_valid) begin
          if (dec_q.size() > 0) d = dec_q.pop_front();
          else if (rand_en)     d = rand_dec();
          else                  d = mk(3, 0, 0, 0, 0);
          bus.fetch_op     = 2'(d.op);
          bus.jump_control = d.jc;
          bus.branch_cond  = d.bc;
          bus.jmp_addr     = 10'(d.jmp);
          bus.jr_addr      = 10'(d.jr);
          issued++;
          if (d.op == 3) begin
            halt_cyc = cyc + 1;
          end else begin
            if (d.op == 0)                 m_pc = (m_pc + 1) % 1024;
            else if (d.op == 2)            m_pc = d.jr;
            else if (d.jc || d.bc)         m_pc = (m_pc + d.jmp) % 1024;
            else                           m_pc = (m_pc + 1) % 1024;
            lat = rand_lat ? int'($urandom_range(0, 4)) : lat_fix;
            e = '{m_pc, int'(mem[m_pc]), issued, cyc + 2 + lat};
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst_n) begin
        chk("fault_implies_halted", 32'(!fault || halted), 1);
        if (bus.instr_valid) begin
          chk("issue_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue_pc",       32'(pc),        32'(e.pc));
            chk("issue_instr",    32'(bus.instr), 32'(e.instr));
            chk("issue_icount",   32'(icount),    32'(e.icnt));
            chk("issue_pc_plus1", 32'(pc_plus1),  32'((e.pc + 1) % 1024));
            chk("issue_cycle",    32'(cyc),       32'(e.cyc));
          end
        end
      end
    end
  end

  task automatic start_run();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    m_pc = int'(RST_PC);
    issued = 0;
    halt_cyc = -1;
    repeat (2) @(negedge clk);
    chk("rst_imem_req",    32'(bus.imem_req),    0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 0);
    chk("rst_halted",      32'(halted),          0);
    chk("rst_fault",       32'(fault),           0);
    chk("rst_pc",          32'(pc),              32'(RST_PC));
    chk("rst_instr",       32'(bus.instr),       0);
    chk("rst_icount",      32'(icount),          0);
    rst_n = 1'b1;
    lat = rand_lat ? int'($urandom_range(0, 4)) : lat_fix;
    if (!no_ack) begin
      e = '{m_pc, int'(mem[m_pc]), 0, cyc + 2 + lat};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk("halt_reached", 32'(halted),  1);
    chk("halt_latency", 32'(cyc),     32'(halt_cyc));
    chk("halt_pc",      32'(pc),      32'(m_pc));
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic wait_issues(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (issued >= n) break;
      @(negedge clk);
    end
    chk("issue_count_reached", 32'(issued >= n), 1);
  endtask

  task automatic check_frozen(input int n, input int frozen_pc);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("halt_no_req",   32'(bus.imem_req),    0);
      chk("halt_no_valid", 32'(bus.instr_valid), 0);
      chk("halt_pc_frozen", 32'(pc),             32'(frozen_pc));
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cnt;
    for (int i = 0; i < 1024; i++) mem[i] = 10'($urandom);
    rand_en = 0; rand_lat = 0; no_ack = 0; lat_fix = 0; lat = 0;
    m_pc = 0; issued = 0; halt_cyc = -1;

    // Sequential fetch with same-cycle ack
    repeat (4) dec_q.push_back(mk(0, 0, 0, 0, 0));
    start_run();
    wait_halt(40);
    chk("seq_icount", 32'(icount), 5);
    chk("seq_pc",     32'(pc),     4);

    // Directed jumps, branches, wrap-around, register jump, halt at 7
    dec_q.push_back(mk(2, 0, 0, 0, 5));
    dec_q.push_back(mk(1, 0, 1, 10'h3FD, 0));
    dec_q.push_back(mk(2, 0, 0, 0, 5));
    dec_q.push_back(mk(1, 0, 0, 10'h3FD, 0));
    dec_q.push_back(mk(2, 0, 0, 0, 1023));
    dec_q.push_back(mk(0, 0, 0, 0, 0));
    dec_q.push_back(mk(2, 0, 0, 0, 3));
    dec_q.push_back(mk(1, 1, 0, 10'h010, 0));
    dec_q.push_back(mk(2, 0, 0, 0, 4));
    dec_q.push_back(mk(2, 0, 0, 0, 10'h155));
    dec_q.push_back(mk(2, 0, 0, 0, 7));
    start_run();
    wait_halt(100);
    chk("jump_halt_pc", 32'(pc), 7);
    check_frozen(6, 7);

    // Three wait cycles per fetch
    lat_fix = 3;
    repeat (3) dec_q.push_back(mk(0, 0, 0, 0, 0));
    start_run();
    wait_halt(60);
    lat_fix = 0;

    // Memory never acks: timeout fault after MAX_WAIT fetch cycles
    no_ack = 1;
    start_run();
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fault) break;
      if (bus.imem_req) cnt++;
    end
    chk("timeout_fault",  32'(fault),  1);
    chk("timeout_halted", 32'(halted), 1);
    chk("timeout_cycles", 32'(cnt),    32'(MAXW));
    check_frozen(5, int'(RST_PC));
    chk("fault_sticky", 32'(fault), 1);
    no_ack = 0;

    // Randomized sequencing with random memory latency
    rand_en = 1; rand_lat = 1;
    start_run();
    wait_issues(80, 80 * 8);
    rand_en = 0;
    wait_halt(20);
    rand_lat = 0;

    // Reset asserted in the middle of a FETCH
    lat_fix = 3;
    repeat (5) dec_q.push_back(mk(0, 0, 0, 0, 0));
    start_run();
    wait_issues(2, 40);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_req) break;
    end
    chk("midfetch_req_seen", 32'(bus.imem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midfetch_req_drop", 32'(bus.imem_req), 0);
    chk("midfetch_pc",       32'(pc),           32'(RST_PC));
    chk("midfetch_fault",    32'(fault),        0);
    chk("midfetch_halted",   32'(halted),       0);
    dec_q.delete();
    lat_fix = 0;
    repeat (2) dec_q.push_back(mk(0, 0, 0, 0, 0));
    start_run();
    wait_halt(30);
    chk("post_reset_pc", 32'(pc), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
